// File: rtl/if_id_skid_if.sv
// Handshake bundle between fetch, the IF/ID boundary register and decode.
// The fetch/decode environment uses the master modport; the stage uses slave.
interface if_id_skid_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_if;
  logic                  ready_if;
  logic [DATA_WIDTH-1:0] instruction_if;
  logic [DATA_WIDTH-1:0] pc_if;
  logic                  pred_taken_if;
  logic                  valid_id;
  logic                  ready_id;
  logic [DATA_WIDTH-1:0] instruction_id;
  logic [DATA_WIDTH-1:0] pc_id;
  logic                  pred_taken_id;

  modport master (
    output valid_if, instruction_if, pc_if, pred_taken_if, ready_id,
    input  ready_if, valid_id, instruction_id, pc_id, pred_taken_id
  );

  modport slave (
    input  valid_if, instruction_if, pc_if, pred_taken_if, ready_id,
    output ready_if, valid_id, instruction_id, pc_id, pred_taken_id
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with valid/ready handshake, optional two-entry skid
// buffer, flush-to-bubble and a saturating count of flushed entries.
module if_id_skid_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter bit          SKID_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  if_id_skid_if.slave          bus
);

  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);
  localparam logic [DATA_WIDTH-1:0] PC_W  = DATA_WIDTH'(PC_RESET);

  // bit0 = main entry valid, bit1 = skid entry valid
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  main_valid;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] main_instr;
  logic [DATA_WIDTH-1:0] main_pc;
  logic                  main_pred;
  logic [DATA_WIDTH-1:0] skid_instr;
  logic [DATA_WIDTH-1:0] skid_pc;
  logic                  skid_pred;
  logic                  ready_q;
  logic                  ready;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  load_main_in;
  logic                  load_main_skid;
  logic                  clear_main;
  logic                  load_skid;
  logic [1:0]            drop_inc;
  logic [CNT_WIDTH:0]    drop_sum;
  logic [CNT_WIDTH-1:0]  drop_nxt;

  assign main_valid = state[0];
  assign skid_valid = state[1];

  always_comb begin
    if (SKID_EN) ready = ready_q;
    else         ready = ~main_valid | bus.ready_id;
  end

  assign in_xfer  = bus.valid_if & ready;
  assign out_xfer = main_valid & bus.ready_id;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    clear_main     = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt  = ST_EMPTY;
      clear_main = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_nxt    = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          // in-only is unreachable without a skid entry since ready is low then
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_nxt  = ST_EMPTY;
            clear_main = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_nxt      = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_nxt  = ST_EMPTY;
          clear_main = 1'b1;
        end
      endcase
    end
  end

  // Entries still held and not taken by decode this cycle are lost on flush.
  assign drop_inc = {1'b0, main_valid & ~out_xfer} + {1'b0, skid_valid};
  assign drop_sum = {1'b0, drop_cnt} + (CNT_WIDTH+1)'(drop_inc);
  assign drop_nxt = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      ready_q    <= 1'b1;
      main_instr <= NOP_W;
      main_pc    <= PC_W;
      main_pred  <= 1'b0;
      skid_instr <= NOP_W;
      skid_pc    <= '0;
      skid_pred  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= ~state_nxt[1];
      if (flush) drop_cnt <= drop_nxt;
      // Main entry is rewritten to the bubble encoding whenever it empties,
      // so the outputs can come straight from the flops.
      if (load_main_in) begin
        main_instr <= bus.instruction_if;
        main_pc    <= bus.pc_if;
        main_pred  <= bus.pred_taken_if;
      end else if (load_main_skid) begin
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
        main_pred  <= skid_pred;
      end else if (clear_main) begin
        main_instr <= NOP_W;
        main_pred  <= 1'b0;
      end
      if (load_skid) begin
        skid_instr <= bus.instruction_if;
        skid_pc    <= bus.pc_if;
        skid_pred  <= bus.pred_taken_if;
      end
    end
  end

  assign bus.ready_if       = ready;
  assign bus.valid_id       = main_valid;
  assign bus.instruction_id = main_instr;
  assign bus.pc_id          = main_pc;
  assign bus.pred_taken_id  = main_pred;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench: drivers push expected entries, a negedge monitor pops them
// on every output transfer of the main DUT; side DUTs cover saturation and SKID_EN=0.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PCR_A  = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        pred;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush_a = 1'b0;
  logic       flush_b = 1'b0;
  logic       flush_c = 1'b0;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [7:0] cnt_c;
  logic       mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;
  ent_t       sb[$];

  if_id_skid_if #(.DATA_WIDTH(32)) ia();
  if_id_skid_if #(.DATA_WIDTH(32)) ib();
  if_id_skid_if #(.DATA_WIDTH(32)) ic();

  if_id_skid_reg #(.DATA_WIDTH(32), .PC_RESET(PCR_A), .SKID_EN(1'b1), .CNT_WIDTH(8))
    dut_a (.clk(clk), .reset(reset), .flush(flush_a), .drop_cnt(cnt_a), .bus(ia.slave));
  if_id_skid_reg #(.DATA_WIDTH(32), .SKID_EN(1'b1), .CNT_WIDTH(2))
    dut_b (.clk(clk), .reset(reset), .flush(flush_b), .drop_cnt(cnt_b), .bus(ib.slave));
  if_id_skid_reg #(.DATA_WIDTH(32), .SKID_EN(1'b0), .CNT_WIDTH(8))
    dut_c (.clk(clk), .reset(reset), .flush(flush_c), .drop_cnt(cnt_c), .bus(ic.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return {pc[19:0], 12'h0B3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    ent_t e;
    e.pc   = pc;
    e.ins  = ins_of(pc);
    e.pred = pc[2];
    sb.push_back(e);
  endtask

  task automatic drv_a(input logic v, input logic [31:0] pc);
    ia.valid_if       = v;
    ia.pc_if          = pc;
    ia.instruction_if = ins_of(pc);
    ia.pred_taken_if  = pc[2];
  endtask

  // Monitor for dut_a: every transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ia.valid_id && ia.ready_id) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_pc", ia.pc_id, 32'hFFFF_FFFF);
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("out_pc", ia.pc_id, e.pc);
          chk("out_instr", ia.instruction_id, e.ins);
          chk("out_pred", {31'd0, ia.pred_taken_id}, {31'd0, e.pred});
        end
      end
      if (!ia.valid_id) begin
        chk("bubble_instr", ia.instruction_id, NOP);
        chk("bubble_pred", {31'd0, ia.pred_taken_id}, 32'd0);
      end
    end
  end

  initial begin
    logic [1:0] sat_exp [4];
    sat_exp = '{2'd2, 2'd3, 2'd3, 2'd3};
    drv_a(1'b0, 32'd0);
    ia.ready_id = 1'b0;
    ib.valid_if = 1'b0; ib.pc_if = '0; ib.instruction_if = '0; ib.pred_taken_if = 1'b0; ib.ready_id = 1'b0;
    ic.valid_if = 1'b0; ic.pc_if = '0; ic.instruction_if = '0; ic.pred_taken_if = 1'b0; ic.ready_id = 1'b0;

    step(); step();
    reset = 1'b0;
    chk("rst_ready_if", {31'd0, ia.ready_if}, 32'd1);
    chk("rst_valid_id", {31'd0, ia.valid_id}, 32'd0);
    chk("rst_instr", ia.instruction_id, NOP);
    chk("rst_pc", ia.pc_id, PCR_A);
    chk("rst_drop", {24'd0, cnt_a}, 32'd0);
    mon_en = 1'b1;

    // Streaming with decode always ready
    ia.ready_id = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv_a(1'b1, 32'(i * 4));
      push(32'(i * 4));
      step();
      chk("stream_valid", {31'd0, ia.valid_id}, 32'd1);
      chk("stream_pc", ia.pc_id, 32'(i * 4));
      chk("stream_ready", {31'd0, ia.ready_if}, 32'd1);
    end
    drv_a(1'b0, 32'd0);
    step();
    chk("stream_drained", {31'd0, ia.valid_id}, 32'd0);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: fill both entries, third entry waits
    ia.ready_id = 1'b0;
    push(32'h100); push(32'h104); push(32'h108);
    drv_a(1'b1, 32'h100); step();
    chk("bp_ready_one", {31'd0, ia.ready_if}, 32'd1);
    drv_a(1'b1, 32'h104); step();
    chk("bp_ready_full", {31'd0, ia.ready_if}, 32'd0);
    chk("bp_main_pc", ia.pc_id, 32'h100);
    drv_a(1'b1, 32'h108); step();
    chk("bp_hold_ready", {31'd0, ia.ready_if}, 32'd0);
    chk("bp_hold_pc", ia.pc_id, 32'h100);
    ia.ready_id = 1'b1;
    #1 chk("bp_ready_registered", {31'd0, ia.ready_if}, 32'd0);
    step();
    chk("bp_second_pc", ia.pc_id, 32'h104);
    chk("bp_ready_back", {31'd0, ia.ready_if}, 32'd1);
    step();
    chk("bp_third_pc", ia.pc_id, 32'h108);
    drv_a(1'b0, 32'd0); step();
    chk("bp_drained", {31'd0, ia.valid_id}, 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Flush while full, incoming entry dropped
    ia.ready_id = 1'b0;
    drv_a(1'b1, 32'h200); step();
    drv_a(1'b1, 32'h204); step();
    drv_a(1'b1, 32'h208); flush_a = 1'b1;
    step();
    flush_a = 1'b0; drv_a(1'b0, 32'd0);
    chk("flfull_valid", {31'd0, ia.valid_id}, 32'd0);
    chk("flfull_instr", ia.instruction_id, NOP);
    chk("flfull_drop", {24'd0, cnt_a}, 32'd2);
    chk("flfull_ready", {31'd0, ia.ready_if}, 32'd1);
    chk("flfull_pc_hold", ia.pc_id, 32'h200);
    ia.ready_id = 1'b1;
    step(); step();
    chk("flfull_no_ghost", {31'd0, ia.valid_id}, 32'd0);

    // Flush with the main entry consumed the same cycle
    drv_a(1'b1, 32'h300); push(32'h300); step();
    drv_a(1'b0, 32'd0); flush_a = 1'b1; step();
    flush_a = 1'b0;
    chk("flout_drop", {24'd0, cnt_a}, 32'd2);
    chk("flout_valid", {31'd0, ia.valid_id}, 32'd0);

    // Flush while full with main consumed: only the skid entry is lost
    ia.ready_id = 1'b0;
    drv_a(1'b1, 32'h400); push(32'h400); step();
    drv_a(1'b1, 32'h404); step();
    drv_a(1'b1, 32'h408); flush_a = 1'b1; ia.ready_id = 1'b1;
    step();
    flush_a = 1'b0; drv_a(1'b0, 32'd0);
    chk("flfullout_drop", {24'd0, cnt_a}, 32'd3);
    chk("flfullout_valid", {31'd0, ia.valid_id}, 32'd0);
    step();
    chk("flfullout_sb_empty", 32'(sb.size()), 32'd0);

    // Saturation with a 2-bit counter
    for (int k = 0; k < 4; k++) begin
      ib.ready_id = 1'b0; ib.valid_if = 1'b1;
      ib.pc_if = 32'(k * 8); ib.instruction_if = ins_of(32'(k * 8));
      step(); step();
      chk("sat_full_ready", {31'd0, ib.ready_if}, 32'd0);
      flush_b = 1'b1; step();
      flush_b = 1'b0;
      chk("sat_drop", {30'd0, cnt_b}, {30'd0, sat_exp[k]});
    end
    ib.valid_if = 1'b0;

    // SKID_EN=0: combinational ready path
    chk("c_ready_empty", {31'd0, ic.ready_if}, 32'd1);
    ic.valid_if = 1'b1; ic.pc_if = 32'h500; ic.instruction_if = ins_of(32'h500);
    ic.ready_id = 1'b0;
    step();
    chk("c_valid", {31'd0, ic.valid_id}, 32'd1);
    chk("c_pc", ic.pc_id, 32'h500);
    chk("c_ready_stall", {31'd0, ic.ready_if}, 32'd0);
    ic.ready_id = 1'b1; ic.pc_if = 32'h504; ic.instruction_if = ins_of(32'h504);
    #1 chk("c_ready_comb", {31'd0, ic.ready_if}, 32'd1);
    step();
    chk("c_pc_next", ic.pc_id, 32'h504);
    chk("c_instr_next", ic.instruction_id, ins_of(32'h504));
    ic.valid_if = 1'b0; step();
    chk("c_empty", {31'd0, ic.valid_id}, 32'd0);
    chk("c_nop", ic.instruction_id, NOP);
    chk("c_pc_hold", ic.pc_id, 32'h504);

    // Reset together with flush while full
    ia.ready_id = 1'b0;
    drv_a(1'b1, 32'h600); step();
    drv_a(1'b1, 32'h604); step();
    chk("rf_full_ready", {31'd0, ia.ready_if}, 32'd0);
    drv_a(1'b0, 32'd0); reset = 1'b1; flush_a = 1'b1;
    step();
    reset = 1'b0; flush_a = 1'b0;
    chk("rf_valid", {31'd0, ia.valid_id}, 32'd0);
    chk("rf_instr", ia.instruction_id, NOP);
    chk("rf_pc", ia.pc_id, PCR_A);
    chk("rf_pred", {31'd0, ia.pred_taken_id}, 32'd0);
    chk("rf_drop", {24'd0, cnt_a}, 32'd0);
    chk("rf_ready", {31'd0, ia.ready_if}, 32'd1);
    step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
